// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states and the
// hardware-loop stack entry layout at the default widths.
package pc_seq_pkg;

  localparam int PC_W_DEF  = 12;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // start_pc/end_pc stand in for loop start/end ("end" is a reserved word)
  typedef struct packed {
    logic [PC_W_DEF-1:0]  start_pc;
    logic [PC_W_DEF-1:0]  end_pc;
    logic [CNT_W_DEF-1:0] count;
  } loop_entry_t;

endpackage

// File: rtl/pc_loop_stack.sv
// Hardware-loop stack: LIFO of {start, end, count} entries with in-place
// top-count decrement and a combined pop+push that replaces the top entry.
module pc_loop_stack
  import pc_seq_pkg::*;
#(
  parameter int LOOP_DEPTH = 4,
  parameter int PC_W       = PC_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic                              push,
  input  logic                              pop,
  input  logic                              dec,
  input  logic [PC_W-1:0]                   push_start,
  input  logic [PC_W-1:0]                   push_end,
  input  logic [CNT_W-1:0]                  push_count,
  output logic [PC_W-1:0]                   top_start,
  output logic [PC_W-1:0]                   top_end,
  output logic [CNT_W-1:0]                  top_count,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(LOOP_DEPTH+1)-1:0]   level
);

  localparam int LVL_W = $clog2(LOOP_DEPTH + 1);
  localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  typedef struct packed {
    logic [PC_W-1:0]  start_pc;
    logic [PC_W-1:0]  end_pc;
    logic [CNT_W-1:0] count;
  } entry_t;

  entry_t            mem [LOOP_DEPTH];
  entry_t            new_e;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;

  assign new_e     = '{start_pc: push_start, end_pc: push_end, count: push_count};
  assign top_idx   = IDX_W'(level - LVL_W'(1));
  assign wr_idx    = IDX_W'(level);
  assign top_start = mem[top_idx].start_pc;
  assign top_end   = mem[top_idx].end_pc;
  assign top_count = mem[top_idx].count;
  assign full      = (level == LVL_W'(LOOP_DEPTH));
  assign empty     = (level == '0);

  // Entry contents need no reset: they are only observed while level > 0.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      level <= '0;
    end else if (push && pop) begin
      mem[top_idx] <= new_e;
    end else begin
      if (pop) begin
        level <= level - LVL_W'(1);
      end else if (push && !full) begin
        mem[wr_idx] <= new_e;
        level       <= level + LVL_W'(1);
      end
      if (dec) begin
        mem[top_idx].count <= mem[top_idx].count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start/halt FSM, vector stall, branches and
// zero-overhead hardware loops backed by pc_loop_stack.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | after reset; pc holds, waits for start
//   ST_RUN    | executing; pc advances when the instruction retires
//   ST_HALTED | HALT retired; pc holds, start relaunches
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int LOOP_DEPTH = 4,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [PC_W-1:0]                  start_pc,
  input  logic                             is_not_vect,
  input  logic                             done_auto_incr,
  input  logic                             is_bne,
  input  logic                             is_beq,
  input  logic                             is_jmp,
  input  logic                             flag_neq,
  input  logic                             flag_eq,
  input  logic [PC_W-1:0]                  branch_target,
  input  logic                             loop_push,
  input  logic [PC_W-1:0]                  loop_end,
  input  logic [CNT_W-1:0]                 loop_count,
  input  logic                             halt,
  output logic [PC_W-1:0]                  pc,
  output logic                             running,
  output logic                             done,
  output logic [$clog2(LOOP_DEPTH+1)-1:0]  loop_level,
  output logic                             err_ovf
);

  state_t            state;
  logic              adv, taken, act, at_end, loop_back;
  logic              do_dec, do_pop, do_push, stk_clr, ovf_set;
  logic              full, empty;
  logic [PC_W-1:0]   pc_inc, pc_next, top_start, top_end;
  logic [CNT_W-1:0]  top_count, push_count;

  assign adv        = is_not_vect | done_auto_incr;
  assign taken      = (is_bne & flag_neq) | (is_beq & flag_eq) | is_jmp;
  assign act        = (state == ST_RUN) && adv && !halt;
  assign pc_inc     = pc + PC_W'(1);
  assign at_end     = !empty && (pc == top_end) && !taken;
  assign loop_back  = at_end && (top_count > CNT_W'(1));
  assign do_dec     = act && loop_back;
  assign do_pop     = act && at_end && !loop_back;
  assign do_push    = act && loop_push;
  assign ovf_set    = do_push && full && !do_pop;
  assign stk_clr    = start && (state != ST_RUN);
  assign push_count = (loop_count == '0) ? CNT_W'(1) : loop_count;
  assign pc_next    = taken ? branch_target : (loop_back ? top_start : pc_inc);

  pc_loop_stack #(
    .LOOP_DEPTH (LOOP_DEPTH),
    .PC_W       (PC_W),
    .CNT_W      (CNT_W)
  ) u_stack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (stk_clr),
    .push       (do_push),
    .pop        (do_pop),
    .dec        (do_dec),
    .push_start (pc_inc),
    .push_end   (loop_end),
    .push_count (push_count),
    .top_start  (top_start),
    .top_end    (top_end),
    .top_count  (top_count),
    .full       (full),
    .empty      (empty),
    .level      (loop_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc      <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
            pc      <= start_pc;
            err_ovf <= 1'b0;
          end
        end
        ST_RUN: begin
          if (adv) begin
            if (halt) begin
              state   <= ST_HALTED;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              pc <= pc_next;
              if (ovf_set) err_ovf <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
